// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced LSB-first over WIDTH bits with valid/ready handshakes.
// Optional SERIAL_ADDER_SUB_EN adds a subtract mode (sub input) and a signed-overflow flag (ovf output).
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADDER_SUB_EN
   output logic             busy,
   input  logic             sub,
   output logic             ovf
`else
   output logic             busy
`endif
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   a_sr, b_sr;
   logic [WIDTH-1:0]   b_load;
   logic               carry, carry_load;
   logic [CNT_W-1:0]   cnt;
   logic               load, step, last;
   logic               fa_s, fa_c;

   // Operand conditioning at the handshake: subtract is a + ~b + 1
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub ? 1'b1 : cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   // Full-adder cell on the current LSBs and the stored carry
   always_comb begin
      fa_s = a_sr[0] ^ b_sr[0] ^ carry;
      fa_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
      last = (cnt == CNT_W'(WIDTH - 1));
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && in_ready) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (out_valid && out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered handshake/status flags tracking the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         busy      <= (state_nxt == RUN);
      end
   end

   // Datapath: operand shifters, result shifter, carry and bit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         sum   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (load) begin
         a_sr  <= a;
         b_sr  <= b_load;
         carry <= carry_load;
         cnt   <= '0;
      end else if (step) begin
         a_sr  <= a_sr >> 1;
         b_sr  <= b_sr >> 1;
         sum   <= {fa_s, sum[WIDTH-1:1]};
         carry <= fa_c;
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // The carry register holds the final carry once the last bit is done
   assign cout = carry;

`ifdef SERIAL_ADDER_SUB_EN
   // Signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (step && last) begin
         ovf <= carry ^ fa_c;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed + random bench for serial_adder_ctrl with a result scoreboard (WIDTH=8).
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         op_sub;
`ifdef SERIAL_ADDER_SUB_EN
   logic         ovf;
`endif

   int   vectors;
   int   miscompares;
   int   cyc;
   int   hs_cyc;
   exp_t sb[$];

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADDER_SUB_EN
      .busy      (busy),
      .sub       (op_sub),
      .ovf       (ovf)
`else
      .busy      (busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, input logic s);
      exp_t         m;
      logic [W-1:0] yv;
      logic         ci;
      logic [W:0]   r;
      yv     = s ? ~y : y;
      ci     = s ? 1'b1 : c;
      r      = {1'b0, x} + {1'b0, yv} + (W+1)'(ci);
      m.sum  = r[W-1:0];
      m.cout = r[W];
      m.ovf  = (x[W-1] == yv[W-1]) && (r[W-1] != x[W-1]);
      return m;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
      check({tag, "_sum"},       64'(sum),       64'd0);
      check({tag, "_cout"},      64'(cout),      64'd0);
`ifdef SERIAL_ADDER_SUB_EN
      check({tag, "_ovf"},       64'(ovf),       64'd0);
`endif
   endtask

   // Called at a negedge; returns at the negedge after the operand handshake
   task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input logic s);
      int k;
      a        = x;
      b        = y;
      cin      = c;
      op_sub   = s;
      in_valid = 1'b1;
      k        = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_in_timeout"}, 64'(k >= 50), 64'd0);
      @(posedge clk);
      sb.push_back(model(x, y, c, s));
      @(negedge clk);
      in_valid = 1'b0;
      hs_cyc   = cyc;
      check({tag, "_busy_run"}, 64'(busy), 64'd1);
   endtask

   // Called at a negedge; waits for the result, checks it and completes the handshake
   task automatic recv(input string tag);
      int   k;
      exp_t e;
      out_ready = 1'b1;
      k         = 0;
      while (!out_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_out_timeout"}, 64'(k >= 50), 64'd0);
      check({tag, "_latency"}, 64'(cyc - hs_cyc), 64'(W));
      if (sb.size() > 0) e = sb.pop_front();
      else e = '0;
      check({tag, "_sum"},  64'(sum),  64'(e.sum));
      check({tag, "_cout"}, 64'(cout), 64'(e.cout));
`ifdef SERIAL_ADDER_SUB_EN
      check({tag, "_ovf"},  64'(ovf),  64'(e.ovf));
`endif
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      exp_t e;
      int   last_cyc;
      vectors     = 0;
      miscompares = 0;
      hs_cyc      = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      a           = '0;
      b           = '0;
      cin         = 1'b0;
      op_sub      = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic adds and carry ripple
      send("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0);
      recv("add35_4a");
      send("ripple", 8'hFF, 8'h00, 1'b1, 1'b0);
      recv("ripple");
      send("allones", 8'hFF, 8'hFF, 1'b1, 1'b0);
      recv("allones");

      // Backpressure: result held, new operands refused until after the result handshake
      send("bp", 8'h12, 8'h34, 1'b0, 1'b0);
      e = model(8'h12, 8'h34, 1'b0, 1'b0);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_sum",   64'(sum),       64'(e.sum));
         check("bp_cout",  64'(cout),      64'(e.cout));
         check("bp_ready", 64'(in_ready),  64'd0);
         if (i == 1) begin
            a        = 8'h11;
            b        = 8'h22;
            cin      = 1'b0;
            in_valid = 1'b1;
         end
         @(negedge clk);
      end
      check("bp_busy_held", 64'(busy), 64'd0);
      void'(sb.pop_front());
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_after_valid", 64'(out_valid), 64'd0);
      check("bp_after_ready", 64'(in_ready),  64'd1);
      check("bp_after_busy",  64'(busy),      64'd0);
      @(posedge clk);
      sb.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      hs_cyc   = cyc;
      check("bp_second_busy", 64'(busy), 64'd1);
      recv("bp_second");

      // Reset in the middle of an operation
      send("midrst", 8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset("midrst");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send("post_rst", 8'h01, 8'h01, 1'b0, 1'b0);
      recv("post_rst");

`ifdef SERIAL_ADDER_SUB_EN
      send("sub10_20", 8'h10, 8'h20, 1'b0, 1'b1);
      recv("sub10_20");
      send("sub80_01", 8'h80, 8'h01, 1'b0, 1'b1);
      recv("sub80_01");
      send("add7f_01", 8'h7F, 8'h01, 1'b0, 1'b0);
      recv("add7f_01");
`endif

      // Back-to-back random traffic with in_valid and out_ready held high
      out_ready = 1'b1;
      last_cyc  = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               int k;
               a        = W'($urandom);
               b        = W'($urandom);
               cin      = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
               op_sub   = 1'($urandom);
`endif
               in_valid = 1'b1;
               k        = 0;
               while (!in_ready && k < 50) begin
                  @(negedge clk);
                  k++;
               end
               @(posedge clk);
               sb.push_back(model(a, b, cin, op_sub));
               @(negedge clk);
            end
            in_valid = 1'b0;
         end
         begin
            for (int j = 0; j < 100; j++) begin
               int   k;
               exp_t r;
               k = 0;
               @(negedge clk);
               while (!out_valid && k < 50) begin
                  @(negedge clk);
                  k++;
               end
               check("rnd_timeout", 64'(k >= 50), 64'd0);
               if (sb.size() > 0) r = sb.pop_front();
               else r = '0;
               check("rnd_sum",  64'(sum),  64'(r.sum));
               check("rnd_cout", 64'(cout), 64'(r.cout));
`ifdef SERIAL_ADDER_SUB_EN
               check("rnd_ovf",  64'(ovf),  64'(r.ovf));
`endif
               if (j > 0) check("rnd_interval", 64'(cyc - last_cyc), 64'(W + 2));
               last_cyc = cyc;
            end
         end
      join
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
